// File: rtl/dmem_arbiter_pkg.sv
// Shared types and MMIO decode for the data-memory arbiter and the DataMEM it fronts.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU      = 2'd1,
        DMA      = 2'd2,
        DMA_LOCK = 2'd3
    } arb_state_e;

    localparam logic [31:0] DMEM_MMIO_BASE = 32'h4000_0000;

    // An address falls in the MMIO window when its top nibble matches the base.
    function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:28] == base[31:28]);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, DMA port and DataMEM port seen by dmem_arbiter.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic        dma_lock;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [31:0] stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_err,
        output mem_addr, mem_wdata, mem_read, mem_write, stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_err,
        input  mem_addr, mem_wdata, mem_read, mem_write, stall_cnt
    );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
module arb_sat_counter #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: holds once LIMIT is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (inc && (count < W'(LIMIT))) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has fixed priority, DMA gets a starvation guard
// and bounded locked bursts. Grants are combinational so read data is valid in the grant cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int          STARVE_LIMIT = 4,
    parameter int          MAX_BURST    = 16,
    parameter logic [31:0] MMIO_BASE    = DMEM_MMIO_BASE
) (
    input  logic         clk,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST);

    arb_state_e  state_r, state_s;
    logic [SW-1:0] starve_cnt_s;
    logic [BW-1:0] burst_cnt_s;
    logic        cpu_first_r;
    logic        dma_err_r;
    logic [31:0] stall_cnt_r;
    logic        cpu_gnt_s, dma_gnt_s;
    logic        starve_full_s, starve_inc_s;
    logic        lock_continue_s, burst_end_s;
    logic        dma_mmio_s, cpu_stall_s;

    assign starve_full_s   = (starve_cnt_s == SW'(STARVE_LIMIT));
    assign dma_mmio_s      = is_mmio(bus.dma_addr, MMIO_BASE);
    assign starve_inc_s    = bus.dma_req & ~dma_gnt_s;
    assign lock_continue_s = dma_gnt_s & bus.dma_lock & (burst_cnt_s < BW'(MAX_BURST - 1));
    assign burst_end_s     = dma_gnt_s & bus.dma_lock & (burst_cnt_s == BW'(MAX_BURST - 1));
    assign cpu_stall_s     = bus.cpu_req & ~cpu_gnt_s & ~reset;

    // Grant selection; a held lock beats everything, then the CPU's post-burst slot.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        if (reset) begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end else if ((state_r == DMA_LOCK) && bus.dma_req) begin
            dma_gnt_s = 1'b1;
        end else if (cpu_first_r && bus.cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (bus.cpu_req && bus.dma_req) begin
            if (starve_full_s) begin
                dma_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else if (bus.cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (bus.dma_req) begin
            dma_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end
    end

    // Next owner of the port.
    always_comb begin
        state_s = IDLE;
        if (cpu_gnt_s) begin
            state_s = CPU;
        end else if (lock_continue_s) begin
            state_s = DMA_LOCK;
        end else if (dma_gnt_s) begin
            state_s = DMA;
        end else begin
            state_s = IDLE;
        end
    end

    // Owner register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Post-burst CPU slot flag, MMIO error pulse and stall statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_first_r <= 1'b0;
            dma_err_r   <= 1'b0;
            stall_cnt_r <= 32'd0;
        end else begin
            cpu_first_r <= burst_end_s;
            dma_err_r   <= dma_gnt_s & bus.dma_we & dma_mmio_s;
            stall_cnt_r <= cpu_stall_s ? (stall_cnt_r + 32'd1) : stall_cnt_r;
        end
    end

    arb_sat_counter #(.LIMIT(STARVE_LIMIT), .W(SW)) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (~starve_inc_s),
        .inc   (starve_inc_s),
        .count (starve_cnt_s)
    );

    arb_sat_counter #(.LIMIT(MAX_BURST - 1), .W(BW)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (~lock_continue_s),
        .inc   (lock_continue_s),
        .count (burst_cnt_s)
    );

    // Port muxes; a DMA write into the MMIO window is granted but never reaches DataMEM.
    always_comb begin
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.cpu_rdata = 32'd0;
        bus.dma_rdata = 32'd0;
        if (cpu_gnt_s) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_read  = ~bus.cpu_we;
            bus.mem_write = bus.cpu_we;
            bus.cpu_rdata = bus.mem_rdata;
        end else if (dma_gnt_s) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_read  = ~bus.dma_we;
            bus.mem_write = bus.dma_we & ~dma_mmio_s;
            bus.dma_rdata = bus.mem_rdata;
        end else begin
            bus.mem_addr  = 32'd0;
        end
    end

    assign bus.dma_gnt   = dma_gnt_s;
    assign bus.cpu_stall = cpu_stall_s;
    assign bus.dma_err   = dma_err_r;
    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a beat-counting reference model.
module tb_dmem_arbiter;

    localparam int STARVE = 4;
    localparam int MAXB   = 16;

    logic clk;
    logic reset;
    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_LIMIT(STARVE), .MAX_BURST(MAXB), .MMIO_BASE(32'h4000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMEM stand-in: 64 words plus the LED register at 0x4000_000C.
    logic [31:0] mem_arr [0:63];
    logic [31:0] led;

    always_comb bus.mem_rdata = (bus.mem_addr == 32'h4000_000C) ? led : mem_arr[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0000_1000 + 32'(i);
            mem_arr[0] <= 32'd76;
            led        <= 32'd0;
        end else if (bus.mem_write) begin
            if (bus.mem_addr == 32'h4000_000C) led <= bus.mem_wdata;
            else mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state, in terms of the arbitration rules rather than RTL registers.
    bit          m_locked;
    int          m_beats;
    int          m_denied;
    bit          m_cpu_first;
    bit          m_err;
    logic [31:0] m_stall;
    int          last_g;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (a == 32'h4000_000C) return led;
        return mem_arr[a[7:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict and compare mid-cycle, advance the model, then move to the next negedge.
    task automatic step();
        int g;
        bit mmio;
        logic [31:0] e_addr, e_wdata, e_crd, e_drd;
        bit e_rd, e_wr, e_stall;
        #1;
        if (reset) begin
            m_locked = 1'b0; m_beats = 0; m_denied = 0;
            m_cpu_first = 1'b0; m_err = 1'b0; m_stall = 32'd0;
            g = 0;
        end else if (m_locked && bus.dma_req) g = 2;
        else if (m_cpu_first && bus.cpu_req) g = 1;
        else if (bus.cpu_req && bus.dma_req) g = (m_denied >= STARVE) ? 2 : 1;
        else if (bus.cpu_req) g = 1;
        else if (bus.dma_req) g = 2;
        else g = 0;

        mmio = (bus.dma_addr[31:28] == 4'h4);
        e_addr = 32'd0; e_wdata = 32'd0; e_crd = 32'd0; e_drd = 32'd0; e_rd = 1'b0; e_wr = 1'b0;
        if (g == 1) begin
            e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
            e_rd = !bus.cpu_we; e_wr = bus.cpu_we; e_crd = ref_rd(bus.cpu_addr);
        end else if (g == 2) begin
            e_addr = bus.dma_addr; e_wdata = bus.dma_wdata;
            e_rd = !bus.dma_we; e_wr = bus.dma_we && !mmio; e_drd = ref_rd(bus.dma_addr);
        end
        e_stall = !reset && bus.cpu_req && (g != 1);

        chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, e_stall});
        chk("dma_gnt",   {31'd0, bus.dma_gnt},   {31'd0, (g == 2)});
        chk("mem_read",  {31'd0, bus.mem_read},  {31'd0, e_rd});
        chk("mem_write", {31'd0, bus.mem_write}, {31'd0, e_wr});
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("cpu_rdata", bus.cpu_rdata, e_crd);
        chk("dma_rdata", bus.dma_rdata, e_drd);
        chk("dma_err",   {31'd0, bus.dma_err}, {31'd0, m_err});
        chk("stall_cnt", bus.stall_cnt, m_stall);

        if (!reset) begin
            if (e_stall) m_stall = m_stall + 32'd1;
            m_err = (g == 2) && bus.dma_we && mmio;
            m_cpu_first = 1'b0;
            if ((g == 2) && bus.dma_lock) begin
                m_beats = m_beats + 1;
                if (m_beats == MAXB) begin
                    m_locked = 1'b0; m_beats = 0; m_cpu_first = 1'b1;
                end else begin
                    m_locked = 1'b1;
                end
            end else begin
                m_locked = 1'b0; m_beats = 0;
            end
            if (bus.dma_req && (g != 2)) m_denied = (m_denied < STARVE) ? m_denied + 1 : STARVE;
            else m_denied = 0;
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h4000_000C + 32'(4 * $urandom_range(0, 2));
        return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    endfunction

    int n;

    initial begin
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0; bus.dma_addr = 32'd0; bus.dma_wdata = 32'd0;
        @(negedge clk); @(negedge clk);

        // Requests during reset must be ignored.
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.dma_lock = 1'b1;
        step();
        chk("rst_stall", bus.stall_cnt, 32'd0);

        // Idle after release.
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
        step();

        // CPU-only read of address 0.
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'd0;
        #1 chk("cpu_rd76", bus.cpu_rdata, 32'd76);
        step();

        // Contention: CPU four cycles, DMA on the fifth.
        bus.dma_req = 1'b1; bus.dma_addr = 32'h8;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_g == 2) n++;
        end
        chk("cont_dma", 32'(n), 32'd2);
        chk("cont_stall", bus.stall_cnt, 32'd2);

        // Locked burst capped at MAX_BURST beats, then one CPU slot.
        bus.cpu_req = 1'b0; bus.dma_lock = 1'b1; bus.dma_addr = 32'h20;
        n = 0;
        for (int i = 0; i < MAXB; i++) begin
            step();
            if (last_g == 2) n++;
        end
        chk("burst_len", 32'(n), 32'd16);
        bus.cpu_req = 1'b1;
        step();
        chk("burst_cpu_slot", 32'(last_g), 32'd1);
        bus.cpu_req = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (last_g == 2) n++;
        end
        chk("burst_resume", 32'(n), 32'd3);

        // MMIO guard on DMA writes; CPU write to the same register lands.
        bus.dma_lock = 1'b0; bus.dma_we = 1'b1; bus.dma_addr = 32'h4000_000C; bus.dma_wdata = 32'h0000_FFFF;
        step();
        chk("mmio_gnt", 32'(last_g), 32'd2);
        chk("mmio_err", {31'd0, bus.dma_err}, 32'd1);
        chk("led_kept", led, 32'd0);
        bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h4000_000C; bus.cpu_wdata = 32'h0000_FFFF;
        step();
        chk("led_set", led, 32'h0000_FFFF);

        // Reset in the middle of a burst; the burst restarts from its first beat.
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h40;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        #1 chk("rst_gnt", {31'd0, bus.dma_gnt}, 32'd0);
        chk("rst_cnt", bus.stall_cnt, 32'd0);
        step();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < MAXB; i++) begin
            step();
            if (last_g == 2) n++;
        end
        chk("rst_burst_len", 32'(n), 32'd16);
        bus.cpu_req = 1'b1;
        step();
        chk("rst_cpu_slot", 32'(last_g), 32'd1);

        // Idle port.
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
        #1 chk("idle_addr", bus.mem_addr, 32'd0);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.cpu_req   = ($urandom_range(0, 9) < 7);
            bus.cpu_we    = ($urandom_range(0, 3) == 0);
            bus.cpu_addr  = rand_addr();
            bus.cpu_wdata = $urandom;
            bus.dma_req   = ($urandom_range(0, 9) < 8);
            bus.dma_we    = ($urandom_range(0, 2) == 0);
            bus.dma_lock  = ($urandom_range(0, 9) < 7);
            bus.dma_addr  = rand_addr();
            bus.dma_wdata = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
